// File: rtl/uart_rx.sv
// Parametrised UART receiver: 2-flop synchroniser, mid-bit sampling FSM with
// false-start rejection, parity/framing/overrun flags and a valid/ack output.
module uart_rx #(
  parameter int CLKS_PER_BIT = 8464,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 2,
  parameter int STOP_BITS    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 data_ack,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam int HALF  = CLKS_PER_BIT / 2;

  localparam logic [CNT_W-1:0] HALF_M1   = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_M1    = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           sync_q, sync_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 frm_q, frm_d;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 data_valid_q, data_valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_err_q, overrun_err_d;
  logic                 rxs;
  logic                 deliver;

  assign rxs = sync_q[1];

  always_comb begin
    // NOTE: every _d gets its default before any branch, so no path can infer a latch.
    sync_d        = {sync_q[0], rx};
    state_d       = state_q;
    cnt_d         = cnt_q + 1'b1;
    idx_d         = idx_q;
    shreg_d       = shreg_q;
    par_d         = par_q;
    frm_d         = frm_q;
    data_out_d    = data_out_q;
    data_valid_d  = data_valid_q;
    parity_err_d  = parity_err_q;
    frame_err_d   = frame_err_q;
    overrun_err_d = overrun_err_q;
    deliver       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rxs) begin
          state_d = S_START;
          idx_d   = '0;
          par_d   = 1'b0;
          frm_d   = 1'b0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          idx_d = '0;
          // Line back high at mid start bit: a glitch, not a frame.
          state_d = rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_M1) begin
          cnt_d   = '0;
          shreg_d = {rxs, shreg_q[DATA_BITS-1:1]};
          if (idx_q == LAST_DATA) begin
            idx_d   = '0;
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_PAR: begin
        if (cnt_q == BIT_M1) begin
          cnt_d   = '0;
          par_d   = (PARITY == 1) ? ~(^shreg_q ^ rxs) : (^shreg_q ^ rxs);
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_M1) begin
          cnt_d = '0;
          frm_d = frm_q | ~rxs;
          if (idx_q == LAST_STOP) begin
            // Leave mid stop bit so a back-to-back start edge is not missed.
            deliver = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (data_ack && data_valid_q) begin
      data_valid_d  = 1'b0;
      overrun_err_d = 1'b0;
    end

    // Delivery takes priority over a same-cycle ack.
    if (deliver) begin
      data_out_d   = shreg_q;
      parity_err_d = par_q;
      frame_err_d  = frm_d;
      data_valid_d = 1'b1;
      if (data_valid_q && !data_ack) overrun_err_d = 1'b1;
    end
  end

  // NOTE: sequential state is written only with nonblocking assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q        <= 2'b11;
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      shreg_q       <= '0;
      par_q         <= 1'b0;
      frm_q         <= 1'b0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      parity_err_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shreg_q       <= shreg_d;
      par_q         <= par_d;
      frm_q         <= frm_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      parity_err_q  <= parity_err_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign parity_err  = parity_err_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: an 8E2 instance and a 7N1 instance, both at 16 clocks/bit,
// driven by serialised frames and compared against expectations from frame content.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk;
  logic       rst_n_a, rx_a, ack_a;
  logic [7:0] dout_a;
  logic       valid_a, perr_a, ferr_a, ovr_a;
  logic       rst_n_b, rx_b, ack_b;
  logic [6:0] dout_b;
  logic       valid_b, perr_b, ferr_b, ovr_b;

  int n_vec = 0;
  int n_err = 0;

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n_a), .rx(rx_a), .data_ack(ack_a),
    .data_out(dout_a), .data_valid(valid_a), .parity_err(perr_a),
    .frame_err(ferr_a), .overrun_err(ovr_a)
  );

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n_b), .rx(rx_b), .data_ack(ack_b),
    .data_out(dout_b), .data_valid(valid_b), .parity_err(perr_b),
    .frame_err(ferr_b), .overrun_err(ovr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       par_bit;
    logic [1:0] stops;     // stops[0] is the first stop bit on the wire
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Even-parity reference: the sent bit must make the total count of ones even.
  function automatic logic model_perr(input logic [7:0] d, input logic pb);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return pb != logic'(ones % 2);
  endfunction

  // Starts driving at the current time; call right after a negedge.
  task automatic send_a(input logic [7:0] d, input logic pb, input logic [1:0] stops);
    rx_a = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_a = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx_a = pb;
    repeat (CPB) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      rx_a = stops[s];
      repeat (CPB) @(negedge clk);
    end
    rx_a = 1'b1;
  endtask

  task automatic send_b(input logic [6:0] d);
    rx_b = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      rx_b = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx_b = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic ack_pulse_a();
    @(negedge clk);
    ack_a = 1'b1;
    @(negedge clk);
    ack_a = 1'b0;
    check("ack_a_valid_low", valid_a, 0);
    check("ack_a_ovr_low", ovr_a, 0);
  endtask

  // Frame with exact latency check: rise after 187 edges from the rx drop
  // (2 sync edges + HALF + 11 bits * 16 + 1).
  task automatic timed_frame_a(input vec_t v);
    repeat (20) @(negedge clk);
    fork
      send_a(v.data, v.par_bit, v.stops);
      begin
        repeat (186) @(negedge clk);
        check("dv_before_rise", valid_a, 0);
        @(negedge clk);
        check("dv_at_rise", valid_a, 1);
      end
    join
    check("vec_data", dout_a, v.exp_data);
    check("vec_perr", perr_a, v.exp_perr);
    check("vec_ferr", ferr_a, v.exp_ferr);
    check("vec_ovr", ovr_a, 0);
  endtask

  vec_t vecs[6];

  initial begin
    logic [7:0] d;
    logic       pb;
    logic [1:0] st;

    vecs[0] = '{8'hA5, 1'b0, 2'b11, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b1, 2'b11, 8'h3C, 1'b1, 1'b0};
    vecs[2] = '{8'h01, 1'b1, 2'b01, 8'h01, 1'b0, 1'b1};
    vecs[3] = '{8'hFF, 1'b0, 2'b11, 8'hFF, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 1'b0, 2'b10, 8'h80, 1'b1, 1'b1};
    vecs[5] = '{8'h00, 1'b0, 2'b11, 8'h00, 1'b0, 1'b0};

    rst_n_a = 1'b0; rst_n_b = 1'b0;
    rx_a = 1'b1; rx_b = 1'b1;
    ack_a = 1'b0; ack_b = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_a_valid", valid_a, 0);
    check("rst_a_data", dout_a, 0);
    check("rst_a_flags", {perr_a, ferr_a, ovr_a}, 0);
    check("rst_b_valid", valid_b, 0);
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      timed_frame_a(vecs[i]);
      ack_pulse_a();
    end

    // 4-clock glitch must be rejected, then a real frame still lands.
    @(negedge clk);
    rx_a = 1'b0;
    repeat (4) @(negedge clk);
    rx_a = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_no_valid", valid_a, 0);
    send_a(8'h55, 1'b0, 2'b11);
    check("after_glitch_valid", valid_a, 1);
    check("after_glitch_data", dout_a, 8'h55);
    check("after_glitch_perr", perr_a, 0);
    ack_pulse_a();

    // Overrun: two words without ack.
    repeat (10) @(negedge clk);
    send_a(8'h11, 1'b0, 2'b11);
    check("ovr_first_data", dout_a, 8'h11);
    check("ovr_first_flag", ovr_a, 0);
    send_a(8'h22, 1'b0, 2'b11);
    check("ovr_data", dout_a, 8'h22);
    check("ovr_valid", valid_a, 1);
    check("ovr_flag", ovr_a, 1);
    ack_pulse_a();

    // Ack exactly in the delivery cycle of the second word.
    repeat (10) @(negedge clk);
    send_a(8'h33, 1'b0, 2'b11);
    @(negedge clk);
    fork
      send_a(8'h44, 1'b0, 2'b11);
      begin
        repeat (186) @(negedge clk);
        ack_a = 1'b1;
        @(negedge clk);
        ack_a = 1'b0;
        check("same_cycle_valid", valid_a, 1);
      end
    join
    check("same_cycle_data", dout_a, 8'h44);
    check("same_cycle_ovr", ovr_a, 0);
    check("same_cycle_valid_hold", valid_a, 1);
    ack_pulse_a();

    // Randomised frames against the content-level model.
    for (int n = 0; n < 20; n++) begin
      d  = 8'($urandom);
      pb = 1'($urandom_range(0, 1));
      st = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      repeat ($urandom_range(12, 30)) @(negedge clk);
      send_a(d, pb, st);
      check("rnd_valid", valid_a, 1);
      check("rnd_data", dout_a, d);
      check("rnd_perr", perr_a, model_perr(d, pb));
      check("rnd_ferr", ferr_a, ~&st);
      ack_pulse_a();
    end

    // 7N1 instance: back-to-back words, then reset mid-frame.
    @(negedge clk);
    send_b(7'h7F);
    check("b_first_data", dout_b, 7'h7F);
    check("b_first_valid", valid_b, 1);
    send_b(7'h00);
    check("b_second_data", dout_b, 7'h00);
    check("b_second_ovr", ovr_b, 1);
    check("b_second_flags", {perr_b, ferr_b}, 0);
    fork
      send_b(7'h15);
      begin
        repeat (60) @(negedge clk);
        rst_n_b = 1'b0;
      end
    join
    check("b_rst_valid", valid_b, 0);
    check("b_rst_data", dout_b, 0);
    check("b_rst_flags", {perr_b, ferr_b, ovr_b}, 0);
    repeat (5) @(negedge clk);
    rst_n_b = 1'b1;
    repeat (30) @(negedge clk);
    check("b_post_rst_idle", valid_b, 0);
    send_b(7'h2A);
    check("b_2a_data", dout_b, 7'h2A);
    check("b_2a_valid", valid_b, 1);
    check("b_2a_flags", {perr_b, ferr_b, ovr_b}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
